// File: rtl/tiny16_core.sv
// tiny16_core: 16-bit multi-cycle CPU, 8x16 register file, Z/C flags, active-low bus strobes.
// Define TINY16_MUL_EN to enable ALU func 8 (MUL); otherwise func 8 is a no-op.
module tiny16_core #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        rd,
    output logic        wr,
    output logic [3:0]  stage,
    output logic        hlt
);
    typedef enum logic [3:0] {
        StFetch     = 4'h0,
        StRead      = 4'h1,
        StExec      = 4'h2,
        StMemAddr   = 4'h3,
        StMemStrobe = 4'h4,
        StHalt      = 4'hF
    } stage_e;

    stage_e      st_q;
    logic [15:0] pc_q, ir_q;
    logic [15:0] regs_q [8];
    logic        z_q, c_q;

    logic [3:0]  op, func;
    logic [2:0]  d_sel, s_sel;
    logic [7:0]  imm8;
    logic [15:0] d_val, s_val, pc_inc, br_target, alu_res;
    logic [16:0] sum, diff, addi;
    logic        br_taken, alu_c, alu_we, alu_fl;
`ifdef TINY16_MUL_EN
    logic [31:0] prod;
    assign prod = {16'h0, d_val} * {16'h0, s_val};
`endif

    assign op        = ir_q[15:12];
    assign d_sel     = ir_q[10:8];
    assign s_sel     = ir_q[6:4];
    assign func      = ir_q[3:0];
    assign imm8      = ir_q[7:0];
    assign d_val     = regs_q[d_sel];
    assign s_val     = regs_q[s_sel];
    assign pc_inc    = pc_q + 16'd1;
    assign br_target = pc_inc + {{6{ir_q[9]}}, ir_q[9:0]};
    assign sum       = {1'b0, d_val} + {1'b0, s_val};
    assign diff      = {1'b0, d_val} - {1'b0, s_val};
    assign addi      = {1'b0, d_val} + {1'b0, {8{imm8[7]}}, imm8};
    assign stage     = st_q;

    always_comb begin
        case (ir_q[11:10])
            2'd0:    br_taken = 1'b1;
            2'd1:    br_taken = z_q;
            2'd2:    br_taken = ~z_q;
            default: br_taken = c_q;
        endcase
    end

    // alu_we: write Rd; alu_fl: update Z/C from alu_res/alu_c
    always_comb begin
        alu_res = d_val;
        alu_c   = c_q;
        alu_we  = 1'b0;
        alu_fl  = 1'b0;
        if (op == 4'h4) begin
            case (func)
                4'h0: begin alu_res = s_val; alu_we = 1'b1; end
                4'h1: begin {alu_c, alu_res} = sum;  alu_we = 1'b1; alu_fl = 1'b1; end
                4'h2: begin {alu_c, alu_res} = diff; alu_we = 1'b1; alu_fl = 1'b1; end
                4'h3: begin alu_res = d_val & s_val; alu_c = 1'b0; alu_we = 1'b1; alu_fl = 1'b1; end
                4'h4: begin alu_res = d_val | s_val; alu_c = 1'b0; alu_we = 1'b1; alu_fl = 1'b1; end
                4'h5: begin alu_res = d_val ^ s_val; alu_c = 1'b0; alu_we = 1'b1; alu_fl = 1'b1; end
                4'h6: begin
                    alu_res = {s_val[14:0], 1'b0}; alu_c = s_val[15];
                    alu_we  = 1'b1; alu_fl = 1'b1;
                end
                4'h7: begin
                    alu_res = {1'b0, s_val[15:1]}; alu_c = s_val[0];
                    alu_we  = 1'b1; alu_fl = 1'b1;
                end
`ifdef TINY16_MUL_EN
                4'h8: begin
                    alu_res = prod[15:0]; alu_c = |prod[31:16];
                    alu_we  = 1'b1; alu_fl = 1'b1;
                end
`endif
                4'h9: begin {alu_c, alu_res} = diff; alu_fl = 1'b1; end
                default: ;
            endcase
        end else if (op == 4'h7) begin
            {alu_c, alu_res} = addi;
            alu_we = 1'b1;
            alu_fl = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= StFetch;
            pc_q     <= RESET_VECTOR;
            ir_q     <= 16'h0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            rd       <= 1'b1;
            wr       <= 1'b1;
            hlt      <= 1'b0;
            address  <= 16'h0;
            data_out <= 16'h0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0;
        end else begin
            case (st_q)
                StFetch: begin
                    address <= pc_q;
                    rd      <= 1'b0;
                    st_q    <= StRead;
                end
                StRead: begin
                    ir_q <= data_in;
                    rd   <= 1'b1;
                    st_q <= StExec;
                end
                StExec: begin
                    pc_q    <= pc_inc;
                    address <= pc_inc;
                    st_q    <= StFetch;
                    case (op)
                        4'h1: begin
                            pc_q    <= pc_q;
                            address <= pc_q;
                            hlt     <= 1'b1;
                            st_q    <= StHalt;
                        end
                        4'h2: regs_q[d_sel] <= {{8{imm8[7]}}, imm8};
                        4'h3: regs_q[d_sel] <= {imm8, d_val[7:0]};
                        4'h4, 4'h7: begin
                            if (alu_we) regs_q[d_sel] <= alu_res;
                            if (alu_fl) begin
                                z_q <= (alu_res == 16'h0);
                                c_q <= alu_c;
                            end
                        end
                        4'h5: begin
                            address <= s_val;
                            st_q    <= StMemAddr;
                        end
                        4'h6: begin
                            address  <= s_val;
                            data_out <= d_val;
                            st_q     <= StMemAddr;
                        end
                        4'h8: if (br_taken) begin
                            pc_q    <= br_target;
                            address <= br_target;
                        end
                        4'h9: begin
                            pc_q    <= s_val;
                            address <= s_val;
                        end
                        default: ;
                    endcase
                end
                StMemAddr: begin
                    if (op == 4'h5) rd <= 1'b0;
                    else            wr <= 1'b0;
                    st_q <= StMemStrobe;
                end
                StMemStrobe: begin
                    if (op == 4'h5) regs_q[d_sel] <= data_in;
                    rd   <= 1'b1;
                    wr   <= 1'b1;
                    st_q <= StFetch;
                end
                default: st_q <= StHalt;
            endcase
        end
    end
endmodule

// File: tb/tb_tiny16_core.sv
// Self-checking bench for tiny16_core: directed scenarios plus random programs
// compared against an instruction-level reference interpreter.
module tb_tiny16_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address, data_in, data_out;
    logic        rd, wr, hlt;
    logic [3:0]  stage;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem  [0:65535];
    logic [15:0] mmem [0:65535];
    logic [15:0] iss_r [8];

    logic [15:0] fetch_q[$];
    logic [3:0]  trace_q[$];
    int          wr_lows, both_low;
    logic [15:0] wr_addr, wr_data, rd_addr;

    tiny16_core #(.RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .data_out(data_out), .rd(rd), .wr(wr), .stage(stage), .hlt(hlt)
    );

    always #5 clk = ~clk;

    initial data_in = 16'h0;
    always @(negedge rd) begin #1; data_in = mem[address]; end
    always @(negedge wr) begin #1; mem[address] = data_out; end

    function automatic logic [15:0] e_ri(input logic [3:0] op, input int d, input int imm);
        return {op, 1'b0, 3'(d), 8'(imm)};
    endfunction
    function automatic logic [15:0] e_alu(input int d, input int s, input int f);
        return {4'h4, 1'b0, 3'(d), 1'b0, 3'(s), 4'(f)};
    endfunction
    function automatic logic [15:0] e_mem(input logic [3:0] op, input int d, input int s);
        return {op, 1'b0, 3'(d), 1'b0, 3'(s), 4'h0};
    endfunction
    function automatic logic [15:0] e_br(input int cond, input int off);
        return {4'h8, 2'(cond), 10'(off)};
    endfunction

    task automatic load_prog(input logic [15:0] p[$]);
        for (int i = 0; i < 256; i++) begin mem[i] = 16'h0; mmem[i] = 16'h0; end
        for (int i = 16'h0F00; i < 16'h0F10; i++) begin mem[i] = 16'h0; mmem[i] = 16'h0; end
        for (int i = 0; i < p.size(); i++) begin mem[i] = p[i]; mmem[i] = p[i]; end
    endtask

    // Reset, release, and clock until HLT, recording bus activity once per cycle.
    task automatic run_dut(output int cyc);
        @(negedge clk) reset = 1'b1;
        fetch_q.delete(); trace_q.delete();
        wr_lows = 0; both_low = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        cyc = 0;
        while (!hlt && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            trace_q.push_back(stage);
            if (stage == 4'h1 && !rd) fetch_q.push_back(address);
            if (stage == 4'h4 && !rd) rd_addr = address;
            if (!wr) begin wr_lows++; wr_addr = address; wr_data = data_out; end
            if (!rd && !wr) both_low++;
        end
        checks++;
        if (!hlt) begin
            errors++;
            $display("FAIL run_timeout: hlt=%0b after %0d cycles, required 1", hlt, cyc);
        end
    endtask

    // Instruction-level reference: executes mmem from address 0 until HLT.
    task automatic iss_run(output int cyc);
        logic [15:0] r [8];
        logic [15:0] pc, ir, a, b;
        logic        z, c, done, taken;
        int          s, imm, off, res, f;
        longint      prod;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        z = 0; c = 0; pc = 0; cyc = 0; done = 0;
        for (int step = 0; step < 5000 && !done; step++) begin
            ir = mmem[pc];
            a = r[ir[10:8]];
            b = r[ir[6:4]];
            cyc += (ir[15:12] == 4'h5 || ir[15:12] == 4'h6) ? 5 : 3;
            pc = pc + 16'd1;
            imm = int'(ir[7:0]);
            if (imm >= 128) imm += 65280;
            case (ir[15:12])
                4'h1: done = 1;
                4'h2: r[ir[10:8]] = 16'(imm);
                4'h3: r[ir[10:8]] = 16'(int'(ir[7:0]) * 256 + int'(a) % 256);
                4'h4: begin
                    f = int'(ir[3:0]);
                    res = -1;
                    case (f)
                        0: r[ir[10:8]] = b;
                        1: begin s = int'(a) + int'(b); res = s % 65536; c = s > 65535; end
                        2, 9: begin
                            res = (int'(a) - int'(b) + 65536) % 65536;
                            c = int'(a) < int'(b);
                        end
                        3: begin res = int'(a & b); c = 0; end
                        4: begin res = int'(a | b); c = 0; end
                        5: begin res = int'(a ^ b); c = 0; end
                        6: begin res = (int'(b) * 2) % 65536; c = int'(b) >= 32768; end
                        7: begin res = int'(b) / 2; c = (int'(b) % 2) == 1; end
`ifdef TINY16_MUL_EN
                        8: begin
                            prod = longint'(a) * longint'(b);
                            res = int'(prod % 65536);
                            c = prod >= 65536;
                        end
`endif
                        default: ;
                    endcase
                    if (res >= 0) begin
                        z = (res == 0);
                        if (f != 9) r[ir[10:8]] = 16'(res);
                    end
                end
                4'h5: r[ir[10:8]] = mmem[b];
                4'h6: mmem[b] = a;
                4'h7: begin
                    s = int'(a) + imm;
                    r[ir[10:8]] = 16'(s);
                    z = (s % 65536) == 0;
                    c = s > 65535;
                end
                4'h8: begin
                    off = int'(ir[9:0]);
                    if (off >= 512) off -= 1024;
                    case (ir[11:10])
                        2'd0: taken = 1;
                        2'd1: taken = z;
                        2'd2: taken = !z;
                        default: taken = c;
                    endcase
                    if (taken) pc = 16'((int'(pc) + off + 65536) % 65536);
                end
                4'h9: pc = b;
                default: ;
            endcase
        end
        if (!done) cyc = -1;
        iss_r = r;
    endtask

    task automatic test_reset();
        logic [15:0] p[$];
        int exp_st[4] = '{0, 1, 2, 0};
        logic exp_rd[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        load_prog(p);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stage, rd, wr, hlt} !== {4'h0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: stage/rd/wr/hlt=%h/%b/%b/%b, required 0/1/1/0",
                     stage, rd, wr, hlt);
        end
        checks++;
        if ({address, data_out} !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: address=%h data_out=%h, required 0000 0000", address, data_out);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (stage !== 4'(exp_st[k]) || rd !== exp_rd[k]) begin
                errors++;
                $display("FAIL first_instr_step%0d: stage=%0h rd=%b, required stage=%0h rd=%b",
                         k, stage, rd, exp_st[k], exp_rd[k]);
            end
            if (k == 1) begin
                checks++;
                if (address !== 16'h0) begin
                    errors++;
                    $display("FAIL first_fetch_addr: address=%h, required 0000", address);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [15:0] p[$];
        int cyc;
        p = '{e_ri(4'h2, 1, 8'h80), e_ri(4'h3, 1, 8'hC0), e_ri(4'h2, 2, 1),
              e_mem(4'h6, 2, 1), 16'h1000};
        load_prog(p);
        mem[16'hC080] = 16'h0;
        run_dut(cyc);
        checks++;
        if (wr_lows !== 1) begin
            errors++; $display("FAIL st_wr_pulses: got %0d low clocks, required 1", wr_lows);
        end
        checks++;
        if (wr_addr !== 16'hC080 || wr_data !== 16'h0001) begin
            errors++;
            $display("FAIL st_bus: address=%h data_out=%h, required c080 0001", wr_addr, wr_data);
        end
        checks++;
        if (mem[16'hC080] !== 16'h0001) begin
            errors++; $display("FAIL st_mem: mem[c080]=%h, required 0001", mem[16'hC080]);
        end
        checks++;
        if (both_low !== 0) begin
            errors++; $display("FAIL st_strobes: both low %0d clocks, required 0", both_low);
        end
        checks++;
        if (cyc !== 17) begin
            errors++; $display("FAIL st_cycles: got %0d, required 17", cyc);
        end
    endtask

    task automatic test_branch();
        logic [15:0] p[$];
        logic [15:0] exp_f[9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd4, 16'd5, 16'd6};
        int cyc;
        p = '{e_ri(4'h2, 3, 8'hFF), e_ri(4'h2, 6, 0), e_ri(4'h3, 6, 8'h0F),
              e_ri(4'h7, 3, 1), e_br(1, -2), e_mem(4'h6, 3, 6), 16'h1000};
        load_prog(p);
        run_dut(cyc);
        checks++;
        if (fetch_q.size() != 9) begin
            errors++; $display("FAIL br_fetch_count: got %0d fetches, required 9", fetch_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (fetch_q[i] !== exp_f[i]) begin
                    errors++;
                    $display("FAIL br_fetch%0d: address=%h, required %h", i, fetch_q[i], exp_f[i]);
                end
            end
        end
        checks++;
        if (mem[16'h0F00] !== 16'h0001) begin
            errors++; $display("FAIL br_r3: stored %h, required 0001", mem[16'h0F00]);
        end
    endtask

    task automatic test_load();
        logic [15:0] p[$];
        logic [3:0] exp_t[6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
        int cyc;
        p = '{e_ri(4'h2, 5, 8'h20), e_mem(4'h5, 4, 5), e_ri(4'h2, 6, 0),
              e_ri(4'h3, 6, 8'h0F), e_mem(4'h6, 4, 6), 16'h1000};
        load_prog(p);
        mem[16'h0020] = 16'h1234;
        run_dut(cyc);
        checks++;
        if (mem[16'h0F00] !== 16'h1234) begin
            errors++; $display("FAIL ld_value: R4=%h, required 1234", mem[16'h0F00]);
        end
        checks++;
        if (rd_addr !== 16'h0020) begin
            errors++; $display("FAIL ld_addr: address=%h, required 0020", rd_addr);
        end
        checks++;
        if (cyc !== 22) begin
            errors++; $display("FAIL ld_cycles: got %0d, required 22", cyc);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (trace_q.size() < 8 || trace_q[i + 2] !== exp_t[i]) begin
                errors++;
                $display("FAIL ld_stage%0d: stage=%h, required %h", i,
                         (trace_q.size() < 8) ? 4'hx : trace_q[i + 2], exp_t[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [15:0] p[$];
        int cyc, bad;
        p = '{16'h0000, 16'hA000, 16'h1000};
        load_prog(p);
        run_dut(cyc);
        checks++;
        if (stage !== 4'hF || hlt !== 1'b1) begin
            errors++; $display("FAIL hlt_state: stage=%h hlt=%b, required f 1", stage, hlt);
        end
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!rd || !wr || stage !== 4'hF || !hlt) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hlt_frozen: %0d active clocks, required 0", bad);
        end
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hlt !== 1'b0 || stage !== 4'h0) begin
            errors++; $display("FAIL hlt_reset: hlt=%b stage=%h, required 0 0", hlt, stage);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd !== 1'b0 || address !== 16'h0) begin
            errors++;
            $display("FAIL hlt_refetch: rd=%b address=%h, required 0 0000", rd, address);
        end
    endtask

    task automatic capture_and_store(inout logic [15:0] p[$], input int regs[$]);
        p.push_back(e_ri(4'h2, 7, 0));
        p.push_back(e_br(2, 1));
        p.push_back(e_ri(4'h2, 7, 1));
        p.push_back(e_br(3, 1));
        p.push_back(e_br(0, 1));
        p.push_back(e_ri(4'h3, 7, 1));
        p.push_back(e_ri(4'h2, 6, 0));
        p.push_back(e_ri(4'h3, 6, 8'h0F));
        foreach (regs[i]) begin
            p.push_back(e_mem(4'h6, regs[i], 6));
            p.push_back(e_ri(4'h7, 6, 1));
        end
        p.push_back(16'h1000);
    endtask

    task automatic test_mul();
        logic [15:0] p[$];
        int r[$];
        int cyc;
        logic [15:0] exp_r1, exp_fl;
`ifdef TINY16_MUL_EN
        exp_r1 = 16'h0000; exp_fl = 16'h0101;
`else
        exp_r1 = 16'h0100; exp_fl = 16'h0000;
`endif
        p = '{e_ri(4'h2, 1, 0), e_ri(4'h3, 1, 1), e_ri(4'h2, 2, 0), e_ri(4'h3, 2, 1),
              e_alu(1, 2, 8)};
        r = '{1, 7};
        capture_and_store(p, r);
        load_prog(p);
        run_dut(cyc);
        checks++;
        if (mem[16'h0F00] !== exp_r1) begin
            errors++; $display("FAIL mul_r1: got %h, required %h", mem[16'h0F00], exp_r1);
        end
        checks++;
        if (mem[16'h0F01] !== exp_fl) begin
            errors++; $display("FAIL mul_flags: got %h, required %h", mem[16'h0F01], exp_fl);
        end
    endtask

    task automatic test_random();
        logic [15:0] p[$];
        int r[$];
        int cyc, icyc, kind, d;
        r = '{0, 1, 2, 3, 4, 5, 7};
        for (int it = 0; it < 4; it++) begin
            p.delete();
            for (int i = 0; i < 6; i++) begin
                p.push_back(e_ri(4'h2, i, $urandom_range(0, 255)));
                p.push_back(e_ri(4'h3, i, $urandom_range(0, 255)));
            end
            for (int i = 0; i < 14; i++) begin
                kind = $urandom_range(0, 9);
                d = $urandom_range(0, 5);
                if (kind <= 5)      p.push_back(e_alu(d, $urandom_range(0, 5), $urandom_range(0, 15)));
                else if (kind <= 7) p.push_back(e_ri(4'h7, d, $urandom_range(0, 255)));
                else if (kind == 8) p.push_back(e_ri(4'h2, d, $urandom_range(0, 255)));
                else                p.push_back(e_ri(4'h3, d, $urandom_range(0, 255)));
            end
            capture_and_store(p, r);
            load_prog(p);
            iss_run(icyc);
            run_dut(cyc);
            checks++;
            if (cyc !== icyc) begin
                errors++; $display("FAIL rand%0d_cycles: got %0d, required %0d", it, cyc, icyc);
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (mem[16'h0F00 + i] !== mmem[16'h0F00 + i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got %h, required %h", it, i,
                             mem[16'h0F00 + i], mmem[16'h0F00 + i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_branch();
        test_load();
        test_halt();
        test_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
